regfile_write_arbiter: RTL

//   Round-robin arbiter sharing the single write port of the 8x16 register file

---
 rtl/regfile_write_arbiter_if.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback sources and the register-file write arbiter.
//   master : writeback side (drives requests and scoreboard reserves, sees grants/write port)
//   slave  : arbiter side   (sees requests, drives grants, register-file write port, pending mask)
// Signals:
//   req_valid/req_address/req_data : per-requester write request, slice i belongs to requester i
//   req_ready                      : one-hot grant
//   rf_load/rf_address/rf_data     : registered register-file write port
//   pending                        : per-register reservation mask
//   reserve_valid/reserve_address  : reservation strobe
interface regfile_write_arbiter_if #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [3*NUM_REQ-1:0]          req_address;
    logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rf_load;
    logic [2:0]                    rf_address;
    logic [DATA_WIDTH-1:0]         rf_data;
    logic [7:0]                    pending;
    logic                          reserve_valid;
    logic [2:0]                    reserve_address;

    modport master (
        output req_valid, req_address, req_data, reserve_valid, reserve_address,
        input  req_ready, rf_load, rf_address, rf_data, pending
    );

    modport slave (
        input  req_valid, req_address, req_data, reserve_valid, reserve_address,
        output req_ready, rf_load, rf_address, rf_data, pending
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the single write port of the 8x16 register file among
// NUM_REQ writeback sources. At most one write is granted per cycle; the winning
// address/data are registered onto the register-file write port.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : regfile_write_arbiter_if.slave (requests, one-hot req_ready grant,
//           rf_load/rf_address/rf_data write port, pending mask, reserve strobe)
// Optional feature: define SCOREBOARD_EN to enable the per-register pending mask;
// otherwise pending is tied to zero and the reserve inputs are ignored.
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int unsigned PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      grant_idx_c;
    logic [PTR_W-1:0]      next_ptr_c;
    logic [NUM_REQ-1:0]    grant_c;
    logic                  found_c;
    int unsigned           pos_c;
    logic                  accept_c;
    logic [ADDR_W-1:0]     sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_data_c;

    logic                  rf_load_q;
    logic [ADDR_W-1:0]     rf_address_q;
    logic [DATA_WIDTH-1:0] rf_data_q;

    // Round-robin search: walk offsets from rr_ptr, first valid requester wins.
    // Only req_valid and rr_ptr feed the grant, so requesters may depend on ready freely.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found_c     = 1'b0;
        pos_c       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos_c = 32'(rr_ptr) + i;
            if (pos_c >= NUM_REQ) begin
                pos_c = pos_c - NUM_REQ;
            end
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found_c && (pos_c == k) && bus.req_valid[k]) begin
                    grant_c[k]  = 1'b1;
                    grant_idx_c = PTR_W'(k);
                    found_c     = 1'b1;
                end
            end
        end
    end

    // Mux the granted requester's payload (grant is one-hot).
    always_comb begin
        sel_addr_c = '0;
        sel_data_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_c[k]) begin
                sel_addr_c = bus.req_address[k*ADDR_W +: ADDR_W];
                sel_data_c = bus.req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept_c      = found_c && !reset;
    assign next_ptr_c    = (grant_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + PTR_W'(1);
    assign bus.req_ready = reset ? '0 : grant_c;

    // Registered write stage; a write in flight is dropped by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= '0;
            rf_load_q    <= 1'b0;
            rf_address_q <= '0;
            rf_data_q    <= '0;
        end else begin
            rf_load_q <= accept_c;
            if (accept_c) begin
                rr_ptr       <= next_ptr_c;
                rf_address_q <= sel_addr_c;
                rf_data_q    <= sel_data_c;
            end
        end
    end

    assign bus.rf_load    = rf_load_q;
    assign bus.rf_address = rf_address_q;
    assign bus.rf_data    = rf_data_q;

`ifdef SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] set_mask_c;
    logic [NUM_REGS-1:0] clr_mask_c;

    // Clear on accept (not on rf_load); a same-edge reserve of the same register wins.
    assign set_mask_c = bus.reserve_valid ? (NUM_REGS'(1) << bus.reserve_address) : '0;
    assign clr_mask_c = accept_c ? (NUM_REGS'(1) << sel_addr_c) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask_c) | set_mask_c;
        end
    end

    assign bus.pending = pending_q;
`else
    logic reserve_unused;

    assign reserve_unused = ^{bus.reserve_valid, bus.reserve_address};
    assign bus.pending    = 8'h00;
`endif
endmodule
